// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a local instruction memory.
// Software fills the memory while the unit is IDLE, then raises run. The unit
// streams words to decode over a valid/ready handshake. It follows redirects
// and stops in HALT once an opcode 6'h3F word is accepted.
module fetch_unit #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          run,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   instruction,
  output logic [AW-1:0] out_pc,
  output logic          halted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  state_t          state_r;
  state_t          state_next_s;
  logic [AW-1:0]   pc_r;
  logic [AW-1:0]   pc_next_s;
  logic            out_valid_r;
  logic            valid_next_s;
  logic [31:0]     instruction_r;
  logic [31:0]     instr_next_s;
  logic [AW-1:0]   out_pc_r;
  logic [AW-1:0]   out_pc_next_s;
  logic            halted_r;
  // Set for the first RUN cycle after start-up: the memory read slot before the first fetch.
  logic            startup_r;
  logic            startup_next_s;
  logic [31:0]     mem_r [0:DEPTH-1];

  logic            in_run_s;
  logic            handshake_s;
  logic            is_halt_word_s;
  logic            halt_take_s;
  logic            fetch_s;
  logic            load_write_s;

  // Decode handshake, HALT acceptance, fetch permission and memory write enable.
  always_comb begin
    in_run_s       = (state_r == ST_RUN);
    handshake_s    = out_valid_r & out_ready;
    is_halt_word_s = (instruction_r[31:26] == HALT_OPCODE);
    // A redirect squashes a presented HALT word, so HALT is taken only without a redirect.
    halt_take_s    = in_run_s & ~redirect_valid & handshake_s & is_halt_word_s;
    fetch_s        = in_run_s & run & ~redirect_valid & ~startup_r & ~halt_take_s
                     & (~out_valid_r | handshake_s);
    load_write_s   = (state_r == ST_IDLE) & load_en;
  end

  // Next-state logic for the IDLE / RUN / HALT controller.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_take_s) begin
          state_next_s = ST_HALT;
        end else if (!run && !valid_next_s) begin
          // Stop only after the last presented word has left the output register.
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output and pc update: redirect has priority, then HALT acceptance, fetch, drain, then hold.
  always_comb begin
    pc_next_s      = pc_r;
    valid_next_s   = out_valid_r;
    instr_next_s   = instruction_r;
    out_pc_next_s  = out_pc_r;
    startup_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          startup_next_s = 1'b1;
        end else begin
          startup_next_s = 1'b0;
        end
      end
      ST_RUN: begin
        startup_next_s = 1'b0;
        if (redirect_valid) begin
          pc_next_s    = redirect_pc;
          valid_next_s = 1'b0;
        end else if (halt_take_s) begin
          valid_next_s = 1'b0;
        end else if (fetch_s) begin
          instr_next_s  = mem_r[pc_r];
          out_pc_next_s = pc_r;
          valid_next_s  = 1'b1;
          // DEPTH is a power of two, so the natural AW-bit wrap goes from DEPTH-1 to 0.
          pc_next_s     = pc_r + {{(AW-1){1'b0}}, 1'b1};
        end else if (handshake_s) begin
          valid_next_s = 1'b0;
        end else begin
          // Stalled or idle-in-RUN: everything holds.
          valid_next_s = out_valid_r;
        end
      end
      ST_HALT: begin
        startup_next_s = 1'b0;
      end
      default: begin
        startup_next_s = 1'b0;
      end
    endcase
  end

  // Controller state register; halted is registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      halted_r  <= 1'b0;
      startup_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      halted_r  <= (state_next_s == ST_HALT);
      startup_r <= startup_next_s;
    end
  end

  // Program counter and presented-instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= AW'(RESET_PC);
      out_valid_r   <= 1'b0;
      instruction_r <= 32'h0000_0000;
      out_pc_r      <= {AW{1'b0}};
    end else begin
      pc_r          <= pc_next_s;
      out_valid_r   <= valid_next_s;
      instruction_r <= instr_next_s;
      out_pc_r      <= out_pc_next_s;
    end
  end

  // Instruction memory write port; it has no reset so that a program survives a reset.
  always_ff @(posedge clk) begin
    if (load_write_s) begin
      mem_r[load_addr] <= load_data;
    end
  end

  assign out_valid   = out_valid_r;
  assign instruction = instruction_r;
  assign out_pc      = out_pc_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed bench for fetch_unit (DEPTH=16).
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic        run;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] instruction;
  logic [3:0]  out_pc;
  logic        halted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        run;
    logic        rdv;
    logic [3:0]  rpc;
    logic        rdy;
    logic        len;
    logic        e_valid;
    logic [3:0]  e_pc;
    logic [31:0] e_instr;
    logic        e_halted;
    logic        chk;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.DEPTH(16), .AW(4), .RESET_PC(0)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .instruction    (instruction),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] prog_word(input int i);
    case (i)
      0: return 32'h0400_0001;
      1: return 32'h0400_0002;
      2: return 32'h0400_0003;
      3: return 32'hFC00_0000;
      default: return 32'h1000_0000 + 32'(i);
    endcase
  endfunction

  task automatic add(input logic rst, input logic r, input logic rdv, input int rpc,
                     input logic rdy, input logic len, input logic ev, input int epc,
                     input logic [31:0] ei, input logic eh, input logic chk);
    vec_t v;
    v.rst = rst; v.run = r; v.rdv = rdv; v.rpc = 4'(rpc); v.rdy = rdy; v.len = len;
    v.e_valid = ev; v.e_pc = 4'(epc); v.e_instr = ei; v.e_halted = eh; v.chk = chk;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = 4'd0; load_data = 32'h0;
    run = 1'b0; redirect_valid = 1'b0; redirect_pc = 4'd0; out_ready = 1'b0;

    // Reset forces the outputs before any clock edge.
    #1;
    check("por_valid", out_valid, 1'b0);
    check("por_halted", halted, 1'b0);
    check("por_pc", out_pc, 4'd0);
    check("por_instr", instruction, 32'h0);

    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_data = prog_word(i);
      step();
    end
    load_en = 1'b0;

    //   rst run rdv rpc rdy len   valid pc  instr          halted chk
    // Program run to HALT: two-cycle start latency, then 0,1,2,3, HALT.
    add(0, 1, 0, 0,  1, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  1, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  1, 0,  1, 0,  32'h0400_0001,  0, 1);
    add(0, 1, 0, 0,  1, 0,  1, 1,  32'h0400_0002,  0, 1);
    add(0, 1, 0, 0,  1, 0,  1, 2,  32'h0400_0003,  0, 1);
    add(0, 1, 0, 0,  1, 0,  1, 3,  32'hFC00_0000,  0, 1);
    add(0, 1, 0, 0,  1, 0,  0, 0,  32'h0,          1, 0);
    add(0, 1, 1, 5,  1, 0,  0, 0,  32'h0,          1, 0);  // redirect and run ignored in HALT
    add(1, 0, 0, 0,  0, 0,  0, 0,  32'h0,          0, 1);  // reset out of HALT
    // Five-cycle stall on out_pc=1.
    add(0, 1, 0, 0,  0, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  0, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  0, 0,  1, 0,  32'h0400_0001,  0, 1);
    add(0, 1, 0, 0,  1, 0,  1, 1,  32'h0400_0002,  0, 1);
    for (int k = 0; k < 5; k++)
      add(0, 1, 0, 0, 0, 0,  1, 1,  32'h0400_0002,  0, 1);
    add(0, 1, 0, 0,  1, 0,  1, 2,  32'h0400_0003,  0, 1);
    // Redirect to 9 while stalled.
    add(0, 1, 1, 9,  0, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  1, 0,  1, 9,  32'h1000_0009,  0, 1);
    add(0, 1, 0, 0,  1, 0,  1, 10, 32'h1000_000A,  0, 1);
    // Wrap: 14, 15, 0, 1.
    add(0, 1, 1, 14, 1, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  1, 0,  1, 14, 32'h1000_000E,  0, 1);
    add(0, 1, 0, 0,  1, 0,  1, 15, 32'h1000_000F,  0, 1);
    add(0, 1, 0, 0,  1, 0,  1, 0,  32'h0400_0001,  0, 1);
    add(0, 1, 0, 0,  1, 0,  1, 1,  32'h0400_0002,  0, 1);
    // Load in RUN is ignored; mem[0] is re-fetched afterwards.
    add(0, 1, 0, 0,  1, 1,  1, 2,  32'h0400_0003,  0, 1);
    add(0, 1, 1, 0,  1, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  1, 0,  1, 0,  32'h0400_0001,  0, 1);
    // run=0: presented word stays until accepted, then IDLE; pc is kept.
    add(0, 0, 0, 0,  0, 0,  1, 0,  32'h0400_0001,  0, 1);
    add(0, 0, 0, 0,  1, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  1, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  1, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  1, 0,  1, 1,  32'h0400_0002,  0, 1);
    // A redirect squashes a presented HALT word; the unit stays in RUN.
    add(0, 1, 1, 3,  0, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  0, 0,  1, 3,  32'hFC00_0000,  0, 1);
    add(0, 1, 1, 6,  1, 0,  0, 0,  32'h0,          0, 0);
    add(0, 1, 0, 0,  1, 0,  1, 6,  32'h1000_0006,  0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      reset          = vecs[i].rst;
      run            = vecs[i].run;
      redirect_valid = vecs[i].rdv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      load_en        = vecs[i].len;
      load_addr      = 4'd0;
      load_data      = 32'hFFFF_FFFF;
      step();
      check($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
      check($sformatf("v%0d_halted", i), halted, vecs[i].e_halted);
      if (vecs[i].chk) begin
        check($sformatf("v%0d_pc", i), out_pc, vecs[i].e_pc);
        check($sformatf("v%0d_instr", i), instruction, vecs[i].e_instr);
      end
    end
    load_en = 1'b0; redirect_valid = 1'b0; reset = 1'b0;

    // Asynchronous reset in the middle of a stall, checked before the next edge.
    run = 1'b1; out_ready = 1'b0;
    step();
    check("stall_pc", out_pc, 4'd6);
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_halted", halted, 1'b0);
    check("arst_pc", out_pc, 4'd0);
    check("arst_instr", instruction, 32'h0);

    // After release the unit idles until run rises.
    step();
    reset = 1'b0; run = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("idle%0d_valid", k), out_valid, 1'b0);
    end
    run = 1'b1;
    step();
    check("restart_e0", out_valid, 1'b0);
    step();
    check("restart_e1", out_valid, 1'b0);
    step();
    check("restart_valid", out_valid, 1'b1);
    check("restart_pc", out_pc, 4'd0);
    check("restart_instr", instruction, 32'h0400_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
